rr_fifo_arbiter_param: RTL

- Parametrised round-robin FIFO arbiter. Successor to the fixed 4-channel, 8-bit arbiter.
- Each of N_CH input channels owns a DEPTH-entry FIFO. One arbiter drains the FIFOs onto a single registered output.
- New relative to the previous generation: configurable channel count, width and depth; skip-empty (work-conserving) mode; output backpressure; per-channel full/empty/overflow status; granted-channel ID.

---
 rtl/rr_fifo_arbiter_param.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rr_fifo_arbiter_param.sv
// Round-robin arbiter draining N_CH per-channel FIFOs onto one registered output.
// Supports strict rotation or work-conserving (skip-empty) channel selection.
module rr_fifo_arbiter_param #(
   parameter int N_CH       = 4,
   parameter int DW         = 8,
   parameter int DEPTH      = 8,
   parameter int SKIP_EMPTY = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH-1:0]         wen,
   input  logic [N_CH*DW-1:0]      din,
   input  logic                    out_ready,
   output logic [DW-1:0]           dout,
   output logic                    valid,
   output logic [$clog2(N_CH)-1:0] grant_id,
   output logic [N_CH-1:0]         full,
   output logic [N_CH-1:0]         empty,
   output logic [N_CH-1:0]         overflow
);

   localparam int IW = $clog2(N_CH);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem_q [N_CH][DEPTH];
   logic [AW-1:0] rd_q  [N_CH];
   logic [AW-1:0] rd_d  [N_CH];
   logic [AW-1:0] wr_q  [N_CH];
   logic [AW-1:0] wr_d  [N_CH];
   logic [CW-1:0] cnt_q [N_CH];
   logic [CW-1:0] cnt_d [N_CH];

   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   gid_q, gid_d;
   logic [DW-1:0]   dout_q, dout_d;
   logic            valid_q, valid_d;
   logic [N_CH-1:0] ovf_q, ovf_d;

   logic            load;
   logic            hit;
   logic [IW-1:0]   sel;
   logic [N_CH-1:0] pop;
   logic [N_CH-1:0] push;

   // Explicit modulo wrap so non-power-of-2 channel counts rotate correctly
   function automatic logic [IW-1:0] add_mod(input logic [IW-1:0] a, input int b);
      int s;
      s = int'(a) + b;
      if (s >= N_CH) s = s - N_CH;
      return s[IW-1:0];
   endfunction

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         empty[i] = (cnt_q[i] == '0);
         full[i]  = (cnt_q[i] == CW'(DEPTH));
      end
   end

   // Descending scan so the smallest offset from ptr wins
   always_comb begin
      load = !valid_q || out_ready;
      sel  = ptr_q;
      hit  = 1'b0;
      if (SKIP_EMPTY != 0) begin
         for (int k = N_CH - 1; k >= 0; k--) begin
            if (!empty[add_mod(ptr_q, k)]) begin
               sel = add_mod(ptr_q, k);
               hit = 1'b1;
            end
         end
      end else begin
         hit = !empty[ptr_q];
      end
   end

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         pop[i]   = load && hit && (sel == IW'(i));
         push[i]  = wen[i] && (!full[i] || pop[i]);
         ovf_d[i] = wen[i] && !push[i];
         cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
         rd_d[i]  = pop[i]  ? rd_q[i] + AW'(1) : rd_q[i];
         wr_d[i]  = push[i] ? wr_q[i] + AW'(1) : wr_q[i];
      end
   end

   always_comb begin
      dout_d  = dout_q;
      valid_d = valid_q;
      gid_d   = gid_q;
      ptr_d   = ptr_q;
      if (load) begin
         valid_d = hit;
         dout_d  = hit ? mem_q[sel][rd_q[sel]] : '0;
         if (SKIP_EMPTY == 0 || hit) begin
            gid_d = sel;
            ptr_d = add_mod(sel, 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= '0;
         gid_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= '0;
         for (int i = 0; i < N_CH; i++) begin
            rd_q[i]  <= '0;
            wr_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         for (int i = 0; i < N_CH; i++) begin
            rd_q[i]  <= rd_d[i];
            wr_q[i]  <= wr_d[i];
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Storage needs no reset; occupancy counters define what is live
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_CH; i++) begin
         if (push[i]) mem_q[i][wr_q[i]] <= din[i*DW +: DW];
      end
   end

   assign dout     = dout_q;
   assign valid    = valid_q;
   assign grant_id = gid_q;
   assign overflow = ovf_q;

endmodule
